// File: rtl/seqmul_arbiter.sv
`default_nettype none
// ============================================================================
// seqmul_arbiter : round-robin sequencer sharing one 8x8 sequential multiplier
//                  among N_REQ requesters; optional WAIT timeout abort is
//                  enabled by defining SEQMUL_ARB_TIMEOUT_EN.
// Revision       : 1.0
// ============================================================================
module seqmul_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_a_i,
    input  logic [8*N_REQ-1:0]   req_b_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic                 rsp_valid_o,
    output logic [2:0]           rsp_id_o,
    output logic [15:0]          rsp_prod_o,
    output logic                 rsp_err_o,
    output logic                 busy_o,
    output logic                 mul_start_o,
    output logic [7:0]           mul_a_o,
    output logic [7:0]           mul_b_o,
    input  logic                 mul_done_i,
    input  logic [15:0]          mul_prod_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e      state_q;
    logic [2:0]  last_q;
    logic [2:0]  rsp_id_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] prod_q;
    logic        rsp_valid_q;
    logic        busy_q;
    logic        start_q;

    logic [7:0]  valid_ext;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic        gnt_found;
    logic [2:0]  gnt_idx;
    logic [7:0]  ready_ext;

    // Widen to the 8-requester maximum so a 3-bit index always selects in range.
    assign valid_ext = 8'(req_valid_i);
    assign a_ext     = 64'(req_a_i);
    assign b_ext     = 64'(req_b_i);

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 3'd0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!gnt_found && valid_ext[3'((int'(last_q) + k) % N_REQ)]) begin
                gnt_found = 1'b1;
                gnt_idx   = 3'((int'(last_q) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        ready_ext = 8'd0;
        if (rst_ni && state_q == S_IDLE && gnt_found) begin
            ready_ext[gnt_idx] = 1'b1;
        end
    end

    assign req_ready_o = ready_ext[N_REQ-1:0];
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_prod_o  = prod_q;
    assign busy_o      = busy_q;
    assign mul_start_o = start_q;
    assign mul_a_o     = a_q;
    assign mul_b_o     = b_q;

`ifdef SEQMUL_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    assign rsp_err_o = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign rsp_err_o      = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            last_q      <= 3'(N_REQ - 1);
            rsp_id_q    <= 3'd0;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            prod_q      <= 16'd0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
`ifdef SEQMUL_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_found) begin
                        a_q     <= a_ext[{gnt_idx, 3'b000} +: 8];
                        b_q     <= b_ext[{gnt_idx, 3'b000} +: 8];
                        last_q  <= gnt_idx;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef SEQMUL_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A done landing on the expiry cycle still counts as a normal completion.
                    if (mul_done_i) begin
                        prod_q      <= mul_prod_i;
                        rsp_id_q    <= last_q;
                        rsp_valid_q <= 1'b1;
`ifdef SEQMUL_ARB_TIMEOUT_EN
                        err_q       <= 1'b0;
`endif
                        state_q     <= S_RESP;
                    end
`ifdef SEQMUL_ARB_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        prod_q      <= 16'd0;
                        rsp_id_q    <= last_q;
                        rsp_valid_q <= 1'b1;
                        err_q       <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seqmul_arbiter.sv
`default_nettype none
// tb_seqmul_arbiter: randomized bench with a transaction-level round-robin scoreboard
// and a behavioural multiplier of programmable latency (0 = never completes).
module tb_seqmul_arbiter;
    localparam int N  = 4;
    localparam int TO = 20;
`ifdef SEQMUL_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req_valid_i;
    logic [8*N-1:0] req_a_i, req_b_i;
    logic [N-1:0]   req_ready_o;
    logic           rsp_valid_o, rsp_err_o, busy_o, mul_start_o, mul_done_i;
    logic [2:0]     rsp_id_o;
    logic [15:0]    rsp_prod_o, mul_prod_i;
    logic [7:0]     mul_a_o, mul_b_o;

    always #5 clk = ~clk;

    seqmul_arbiter #(.N_REQ(N), .TIMEOUT(TO)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
        .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_prod_o(rsp_prod_o),
        .rsp_err_o(rsp_err_o), .busy_o(busy_o),
        .mul_start_o(mul_start_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
        .mul_done_i(mul_done_i), .mul_prod_i(mul_prod_i)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // requester side
    logic       rv[N];
    logic [7:0] ra[N], rb[N];
    logic [N-1:0] hold_mask = '0;
    int  rand_prob = 0;
    bit  rand_lat  = 1'b0;
    int  next_lat  = 4;

    // scoreboard: at most one transaction in flight
    bit         pending = 1'b0;
    int         t_id;
    logic [7:0] t_a, t_b;
    int         exp_start = -1, exp_rsp = -1;
    bit         exp_err;
    int         last_m = N - 1;
    int         acc_prev = -1;
    int         cur_lat = 0;
    int         glog[$];

    // multiplier model
    int         m_rem = 0;
    logic [7:0] m_a, m_b;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid_i[i]       = rv[i];
            req_a_i[8*i +: 8]    = ra[i];
            req_b_i[8*i +: 8]    = rb[i];
        end
    endtask

    function automatic logic [7:0] rand_op();
        int s;
        s = $urandom_range(9);
        if (s == 0) return 8'd0;
        if (s == 1) return 8'd255;
        return 8'($urandom);
    endfunction

    function automatic int rr_pick();
        int j;
        for (int k = 1; k <= N; k++) begin
            j = (last_m + k) % N;
            if (rv[j]) return j;
        end
        return -1;
    endfunction

    function automatic bit any_rv();
        for (int i = 0; i < N; i++) if (rv[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic post(input int id, input logic [7:0] a, input logic [7:0] b);
        rv[id] = 1'b1; ra[id] = a; rb[id] = b;
    endtask

    task automatic step();
        int g, eff;
        bit done_rsp;
        logic [N-1:0] er;
        @(negedge clk);
        cyc++;
        done_rsp = 1'b0;
        if (!rst_n) begin
            m_rem = 0; mul_done_i = 1'b0;
        end else if (mul_start_o) begin
            m_rem = cur_lat; m_a = mul_a_o; m_b = mul_b_o; mul_done_i = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            mul_done_i = (m_rem == 0);
            mul_prod_i = (m_rem == 0) ? 16'(m_a) * 16'(m_b) : 16'($urandom);
        end else begin
            mul_done_i = 1'b0;
            mul_prod_i = 16'($urandom);
        end

        check_val("busy", 32'(busy_o), 32'(pending));
        check_val("mul_start", 32'(mul_start_o), 32'(cyc == exp_start));
        if (cyc == exp_start) begin
            check_val("mul_a", 32'(mul_a_o), 32'(t_a));
            check_val("mul_b", 32'(mul_b_o), 32'(t_b));
        end
        check_val("rsp_valid", 32'(rsp_valid_o), 32'(cyc == exp_rsp));
        if (cyc == exp_rsp) begin
            check_val("rsp_id", 32'(rsp_id_o), 32'(t_id));
            check_val("rsp_prod", 32'(rsp_prod_o), exp_err ? 32'd0 : 32'(16'(t_a) * 16'(t_b)));
            check_val("rsp_err", 32'(rsp_err_o), 32'(exp_err));
            done_rsp = 1'b1;
        end

        // the handshake completed at the previous edge; requester drops or reloads now
        if (acc_prev >= 0) begin
            if (hold_mask[acc_prev]) begin
                ra[acc_prev] = rand_op(); rb[acc_prev] = rand_op();
            end else begin
                rv[acc_prev] = 1'b0;
            end
            acc_prev = -1;
        end
        if (rand_prob > 0) begin
            for (int i = 0; i < N; i++) begin
                if (!rv[i] && $urandom_range(99) < rand_prob) post(i, rand_op(), rand_op());
            end
        end
        drive();
        #1;
        g  = pending ? -1 : rr_pick();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check_val("req_ready", 32'(req_ready_o), 32'(er));
        for (int i = 0; i < N; i++) begin
            if (req_ready_o[i]) begin
                glog.push_back(i);
                break;
            end
        end
        if (g >= 0) begin
            pending   = 1'b1;
            t_id      = g; t_a = ra[g]; t_b = rb[g];
            last_m    = g;
            acc_prev  = g;
            cur_lat   = rand_lat ? int'($urandom_range(1, TO)) : next_lat;
            exp_start = cyc + 1;
            if (TO_EN && (cur_lat == 0 || cur_lat > TO)) begin
                eff = TO; exp_err = 1'b1;
            end else begin
                eff = cur_lat; exp_err = 1'b0;
            end
            exp_rsp = cyc + 2 + eff;
        end
        if (done_rsp) pending = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((pending || acc_prev >= 0 || any_rv()) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) check_val({tag, "_bound"}, 32'(n), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_val("rst_req_ready", 32'(req_ready_o), 32'd0);
        check_val("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check_val("rst_rsp_id",    32'(rsp_id_o),    32'd0);
        check_val("rst_rsp_prod",  32'(rsp_prod_o),  32'd0);
        check_val("rst_rsp_err",   32'(rsp_err_o),   32'd0);
        check_val("rst_busy",      32'(busy_o),      32'd0);
        check_val("rst_mul_start", 32'(mul_start_o), 32'd0);
        check_val("rst_mul_a",     32'(mul_a_o),     32'd0);
        check_val("rst_mul_b",     32'(mul_b_o),     32'd0);
        pending = 1'b0; exp_start = -1; exp_rsp = -1; last_m = N - 1;
        acc_prev = -1; m_rem = 0; mul_done_i = 1'b0;
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
        drive();
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin : main
        int b_exp[5];
        int n;
        b_exp = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b0; ra[i] = 8'd0; rb[i] = 8'd0;
        end
        req_valid_i = '0; req_a_i = '0; req_b_i = '0;
        mul_done_i = 1'b0; mul_prod_i = 16'd0;
        #2;
        do_reset();

        // single request from requester 2
        glog.delete();
        next_lat = 16;
        post(2, 8'd13, 8'd11);
        wait_idle("single");
        check_val("single_grant", glog.size() > 0 ? 32'(glog[0]) : 32'hFFFF_FFFF, 32'd2);
        check_val("single_prod_hold", 32'(rsp_prod_o), 32'd143);

        // all requesters held continuously after reset
        do_reset();
        glog.delete();
        rand_lat  = 1'b1;
        hold_mask = '1;
        for (int i = 0; i < N; i++) post(i, rand_op(), rand_op());
        n = 0;
        while (glog.size() < 5 && n < 500) begin
            step();
            n++;
        end
        hold_mask = '0;
        wait_idle("hold");
        for (int k = 0; k < 5; k++)
            check_val("rr_order", k < glog.size() ? 32'(glog[k]) : 32'hFFFF_FFFF, 32'(b_exp[k]));
        rand_lat = 1'b0;

        // extreme operands
        next_lat = 16;
        post(0, 8'd255, 8'd255);
        wait_idle("ext1");
        check_val("ext_max", 32'(rsp_prod_o), 32'd65025);
        post(1, 8'd0, 8'd200);
        wait_idle("ext2");
        check_val("ext_zero", 32'(rsp_prod_o), 32'd0);

        // priority right after requester 1 was served
        next_lat = 3;
        post(1, 8'd5, 8'd6);
        wait_idle("prio0");
        glog.delete();
        post(1, 8'd21, 8'd3);
        post(3, 8'd17, 8'd9);
        wait_idle("prio");
        check_val("prio_first",  glog.size() > 0 ? 32'(glog[0]) : 32'hFFFF_FFFF, 32'd3);
        check_val("prio_second", glog.size() > 1 ? 32'(glog[1]) : 32'hFFFF_FFFF, 32'd1);

        // reset while waiting on the multiplier
        next_lat = 16;
        post(1, 8'd77, 8'd3);
        n = 0;
        while ((exp_start < 0 || cyc < exp_start + 3) && n < 50) begin
            step();
            n++;
        end
        check_val("wait_reached", 32'(busy_o), 32'd1);
        do_reset();
        glog.delete();
        next_lat = 4;
        post(0, 8'd9, 8'd9);
        post(2, 8'd8, 8'd8);
        wait_idle("post_rst");
        check_val("post_rst_first", glog.size() > 0 ? 32'(glog[0]) : 32'hFFFF_FFFF, 32'd0);

        // randomized traffic
        rand_lat  = 1'b1;
        rand_prob = 15;
        repeat (400) step();
        rand_prob = 0;
        wait_idle("random");
        rand_lat = 1'b0;

`ifdef SEQMUL_ARB_TIMEOUT_EN
        // multiplier never completes: abort, then a normal transaction
        next_lat = 0;
        post(2, 8'd40, 8'd40);
        wait_idle("to_abort");
        check_val("to_err_hold",  32'(rsp_err_o),  32'd1);
        check_val("to_prod_hold", 32'(rsp_prod_o), 32'd0);
        next_lat = 5;
        post(3, 8'd7, 8'd9);
        wait_idle("to_after");
        check_val("to_after_prod", 32'(rsp_prod_o), 32'd63);
        check_val("to_after_err",  32'(rsp_err_o),  32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
